axis_rr_arbiter: RTL and testbench
==================================

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 SHALL have parameter N_INPUTS, default 4, number of AXI-Stream requesters (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, TDATA width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port s_tdata  input  N_INPUTS x DATA_WIDTH  requester data.
REQ-006 SHALL have port s_tvalid  input  N_INPUTS  requester valid.
REQ-007 SHALL have port s_tlast  input  N_INPUTS  requester end-of-packet.
REQ-008 SHALL have port s_tready  output  N_INPUTS  requester ready.
REQ-009 SHALL have port m_tdata  output  DATA_WIDTH  shared-output data, registered.
REQ-010 SHALL have port m_tvalid  output  1  shared-output valid, registered.
REQ-011 SHALL have port m_tlast  output  1  shared-output end-of-packet, registered.
REQ-012 SHALL have port m_tready  input  1  downstream ready.
REQ-013 SHALL have port grant_idx  output  clog2(N_INPUTS)  index of the current or most recent grantee.
REQ-014 SHALL have port busy  output  1  high while a grant is held (state BUSY).

Function
REQ-015 SHALL implement two states: IDLE (no grant) and BUSY (grant held by grant_idx).
REQ-016 In IDLE with any s_tvalid high, SHALL select the first requester with s_tvalid high, searching upward from (last_grant+1) mod N_INPUTS with wrap-around, and enter BUSY with grant_idx set to that requester on the next edge.
REQ-017 In IDLE with no s_tvalid high, SHALL remain in IDLE with grant_idx unchanged.
REQ-018 SHALL drive s_tready[i] = busy && (i == grant_idx) && (!m_tvalid || m_tready); all other s_tready bits SHALL be 0.
REQ-019 On a grantee handshake (s_tvalid && s_tready at grant_idx), SHALL load m_tdata/m_tlast from that input and set m_tvalid to 1 on the next edge, giving one-cycle latency.
REQ-020 On m_tvalid && m_tready with no new handshake in the same cycle, SHALL clear m_tvalid; a simultaneous new handshake SHALL keep m_tvalid at 1 with the new beat.
REQ-021 In BUSY, SHALL sustain one beat per cycle while the grantee's s_tvalid and m_tready stay high.
REQ-022 SHALL hold m_tdata/m_tlast stable while m_tvalid && !m_tready.
REQ-023 On release (REQ-033/034), SHALL return to IDLE, set last_grant = grant_idx, and incur exactly one arbitration bubble cycle before the next grant.
REQ-024 A requester dropping s_tvalid mid-grant SHALL NOT release the grant.
REQ-025 A single active requester SHALL be re-granted repeatedly: with last_grant = k and only k requesting, the search wraps back to k.
REQ-026 No requester SHALL wait more than N_INPUTS-1 other grants once its s_tvalid is high.

Reset
REQ-027 While rst_n is low, m_tvalid, m_tlast and busy SHALL be 0.
REQ-028 While rst_n is low, all s_tready bits SHALL be 0.
REQ-029 While rst_n is low, grant_idx SHALL be 0, last_grant SHALL be N_INPUTS-1 (first search starts at input 0), and the state SHALL be IDLE.
REQ-030 m_tdata SHALL be don't-care at reset.
REQ-031 Reset asserted mid-packet SHALL discard the registered beat and any held grant immediately.
REQ-032 Operation SHALL resume from IDLE on the first rising edge after rst_n deasserts.

Configuration
REQ-033 With macro ARB_PACKET_LOCK_EN defined, the grant SHALL be held until the grantee's s_tlast beat handshakes, then released; packets from different inputs SHALL never interleave.
REQ-034 Without ARB_PACKET_LOCK_EN, the grant SHALL be released after every accepted beat, s_tlast SHALL be forwarded unchanged but SHALL NOT affect arbitration, and beats SHALL interleave round-robin.

Verification
REQ-035 Reset state: hold rst_n low with all s_tvalid = 1 -> s_tready = 0, m_tvalid = 0, busy = 0, grant_idx = 0.
REQ-036 Packet lock (ARB_PACKET_LOCK_EN): inputs 0 and 2 each present 3-beat packets (0xA0..A2, 0xC0..C2) and m_tready = 1 -> output sequence A0 A1 A2, one bubble, then C0 C1 C2, with m_tlast on A2 and C2.
REQ-037 Fairness: all 4 inputs continuously valid with 1-beat packets -> grant_idx sequence 0,1,2,3,0 and no input granted twice before the others.
REQ-038 Backpressure: m_tready = 0 for 5 cycles mid-packet -> m_tdata held constant, only one beat accepted from the grantee, and no data loss after m_tready returns to 1.
REQ-039 No lock (macro undefined): inputs 1 and 3 each valid with 2-beat packets -> output beats alternate 1,3,1,3 with bubbles between them.
REQ-040 Reset mid-packet: assert rst_n low after beat 2 of 4 -> m_tvalid = 0 immediately, and the next grant after reset goes to the lowest-index valid input.

Source files
------------

// File: rtl/axis_rr_arbiter_if.sv
// rtl/axis_rr_arbiter_if.sv - AXI-Stream requester/shared-output bundle for the round-robin arbiter
// slave modport is the arbiter's view; master modport is the view of whoever drives it.

interface axis_rr_arbiter_if #(
  parameter int N_INPUTS   = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int IDX_W = $clog2(N_INPUTS);

  logic [N_INPUTS-1:0][DATA_WIDTH-1:0] s_tdata;
  logic [N_INPUTS-1:0]                 s_tvalid;
  logic [N_INPUTS-1:0]                 s_tlast;
  logic [N_INPUTS-1:0]                 s_tready;

  logic [DATA_WIDTH-1:0]               m_tdata;
  logic                                m_tvalid;
  logic                                m_tlast;
  logic                                m_tready;

  logic [IDX_W-1:0]                    grant_idx;
  logic                                busy;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, grant_idx, busy
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, grant_idx, busy
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - round-robin AXI-Stream N:1 arbiter with a registered output stage
// ARB_PACKET_LOCK_EN holds each grant until the grantee's tlast beat; otherwise grants are per beat.

module axis_rr_arbiter #(
  parameter int N_INPUTS   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  axis_rr_arbiter_if.slave    bus
);
  localparam int               IDX_W    = $clog2(N_INPUTS);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_INPUTS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]        last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic                    m_tlast_q, m_tlast_d;

  logic [N_INPUTS-1:0]     s_tready_c;
  logic                    busy_c;
  logic                    out_free;
  logic                    grant_hs;
  logic                    release_c;
  logic                    any_req;
  logic [IDX_W-1:0]        rr_pick;

  // Iterating offsets high-to-low lets the nearest requester after `last` win;
  // offset N_INPUTS lands back on `last`, so a lone requester is re-granted.
  function automatic logic [IDX_W-1:0] rr_search(
    input logic [N_INPUTS-1:0] req,
    input logic [IDX_W-1:0]    last
  );
    logic [IDX_W-1:0] pick;
    int               cand;
    pick = last;
    for (int off = N_INPUTS; off >= 1; off--) begin
      cand = int'(last) + off;
      if (cand >= N_INPUTS) begin
        cand = cand - N_INPUTS;
      end
      if (req[cand[IDX_W-1:0]]) begin
        pick = cand[IDX_W-1:0];
      end
    end
    return pick;
  endfunction

  assign busy_c   = (state_q == ST_BUSY);
  assign out_free = !m_tvalid_q || bus.m_tready;
  assign grant_hs = busy_c && out_free && bus.s_tvalid[grant_idx_q];
  assign any_req  = |bus.s_tvalid;
  assign rr_pick  = rr_search(bus.s_tvalid, last_grant_q);

`ifdef ARB_PACKET_LOCK_EN
  assign release_c = grant_hs && bus.s_tlast[grant_idx_q];
`else
  assign release_c = grant_hs;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= LAST_RST;
      m_tdata_q    <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      m_tdata_q    <= m_tdata_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
    end
  end

  // The IDLE cycle after a release is the arbitration bubble.
  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d     = ST_BUSY;
          grant_idx_d = rr_pick;
        end
      end
      ST_BUSY: begin
        if (release_c) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    s_tready_c = '0;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tvalid_d = m_tvalid_q;
    for (int i = 0; i < N_INPUTS; i++) begin
      s_tready_c[i] = busy_c && (IDX_W'(i) == grant_idx_q) && out_free;
    end
    if (grant_hs) begin
      m_tdata_d  = bus.s_tdata[grant_idx_q];
      m_tlast_d  = bus.s_tlast[grant_idx_q];
      m_tvalid_d = 1'b1;
    end else if (bus.m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  assign bus.s_tready  = s_tready_c;
  assign bus.m_tdata   = m_tdata_q;
  assign bus.m_tvalid  = m_tvalid_q;
  assign bus.m_tlast   = m_tlast_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.busy      = busy_c;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb/tb_axis_rr_arbiter.sv - randomized self-checking bench for axis_rr_arbiter
// Expected beat order comes from a queue-level round-robin model.

module tb_axis_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
`ifdef ARB_PACKET_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_rr_arbiter_if #(.N_INPUTS(N), .DATA_WIDTH(DW)) bus();

  axis_rr_arbiter #(.N_INPUTS(N), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW:0] mem [N][64];
  int          head [N];
  int          tail [N];
  logic [DW:0] exp_q [$];
  logic [DW:0] obs_q [$];
  int          obs_cyc [$];
  int          grant_q [$];
  int          cyc = 0;
  int          hs_cnt = 0;
  int          rdy_pct = 100;
  int          gap_pct = 0;
  int          model_last = N - 1;
  logic        busy_prev = 1'b0;

  function automatic void clear_queues();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    grant_q.delete();
  endfunction

  function automatic void push_beat(int src, logic [DW-1:0] d, logic l);
    mem[src][tail[src]] = {l, d};
    tail[src]++;
  endfunction

  function automatic bit is_first(int i);
    if (head[i] == 0) return 1'b1;
    return mem[i][head[i]-1][DW];
  endfunction

  // Round robin over non-empty queues: whole packets with lock, single beats without.
  function automatic void build_expected();
    int h [N];
    int pick;
    int c;
    bit done;
    for (int i = 0; i < N; i++) h[i] = head[i];
    do begin
      pick = -1;
      for (int off = 1; off <= N; off++) begin
        c = (model_last + off) % N;
        if (pick < 0 && h[c] < tail[c]) pick = c;
      end
      if (pick >= 0) begin
`ifdef ARB_PACKET_LOCK_EN
        done = 1'b0;
        while (!done && h[pick] < tail[pick]) begin
          exp_q.push_back(mem[pick][h[pick]]);
          done = mem[pick][h[pick]][DW];
          h[pick]++;
        end
`else
        done = 1'b1;
        exp_q.push_back(mem[pick][h[pick]]);
        h[pick]++;
`endif
        model_last = pick;
      end
    end while (pick >= 0);
  endfunction

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i]) begin
        bus.s_tdata[i]  = mem[i][head[i]][DW-1:0];
        bus.s_tlast[i]  = mem[i][head[i]][DW];
        bus.s_tvalid[i] = !(LOCK && !is_first(i) && ($urandom_range(99) < gap_pct));
      end else begin
        bus.s_tdata[i]  = '0;
        bus.s_tlast[i]  = 1'b0;
        bus.s_tvalid[i] = 1'b0;
      end
    end
    bus.m_tready = ($urandom_range(99) < rdy_pct);
    #1;
    for (int i = 0; i < N; i++) begin
      if (bus.s_tvalid[i] && bus.s_tready[i]) begin
        head[i]++;
        hs_cnt++;
      end
    end
    if (bus.m_tvalid && bus.m_tready) begin
      obs_q.push_back({bus.m_tlast, bus.m_tdata});
      obs_cyc.push_back(cyc);
    end
    if (bus.busy && !busy_prev) grant_q.push_back(int'(bus.grant_idx));
    busy_prev = bus.busy;
    cyc++;
  endtask

  task automatic run_for(int n_target, int budget);
    for (int k = 0; k < budget && obs_q.size() < n_target; k++) step();
  endtask

  task automatic drive_idle();
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    bus.s_tdata  = '0;
    bus.m_tready = 1'b1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = N - 1;
    busy_prev = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.s_tvalid = '1;
    bus.s_tlast  = '1;
    bus.s_tdata  = '1;
    bus.m_tready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.s_tready !== 4'b0000) begin n_err++; $display("FAIL reset_s_tready: got %b want 0000", bus.s_tready); end
    n_cmp++; if (bus.m_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_m_tvalid: got %b want 0", bus.m_tvalid); end
    n_cmp++; if (bus.m_tlast !== 1'b0) begin n_err++; $display("FAIL reset_m_tlast: got %b want 0", bus.m_tlast); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.grant_idx !== 2'd0) begin n_err++; $display("FAIL reset_grant_idx: got %0d want 0", bus.grant_idx); end
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    model_last = N - 1;
    busy_prev = 1'b0;
  endtask

  task automatic test_fairness();
    int fair_exp [5] = '{0, 1, 2, 3, 0};
    reset_dut();
    clear_queues();
    rdy_pct = 100;
    gap_pct = 0;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < N; i++) push_beat(i, {8'(i), 24'hF00000 + 24'(j)}, 1'b1);
    build_expected();
    run_for(exp_q.size(), 100);
    n_cmp++; if (grant_q.size() < 5) begin n_err++; $display("FAIL fair_grant_count: got %0d want >=5", grant_q.size()); end
    for (int k = 0; k < 5 && k < grant_q.size(); k++) begin
      n_cmp++; if (grant_q[k] !== fair_exp[k]) begin n_err++; $display("FAIL fair_grant[%0d]: got %0d want %0d", k, grant_q[k], fair_exp[k]); end
    end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL fair_beat_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_cmp++; if (obs_q[k] !== exp_q[k]) begin n_err++; $display("FAIL fair_beat[%0d]: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_packet_mode();
    logic [DW:0] want [$];
    int          gap_want [$];
    reset_dut();
    clear_queues();
    rdy_pct = 100;
    gap_pct = 0;
`ifdef ARB_PACKET_LOCK_EN
    for (int j = 0; j < 3; j++) begin
      push_beat(0, 32'hA0 + 32'(j), (j == 2));
      push_beat(2, 32'hC0 + 32'(j), (j == 2));
    end
    for (int j = 0; j < 3; j++) want.push_back({(j == 2), 32'hA0 + 32'(j)});
    for (int j = 0; j < 3; j++) want.push_back({(j == 2), 32'hC0 + 32'(j)});
    gap_want = '{1, 1, 2, 1, 1};
`else
    for (int j = 0; j < 2; j++) begin
      push_beat(1, 32'h10 + 32'(j), (j == 1));
      push_beat(3, 32'h30 + 32'(j), (j == 1));
    end
    want.push_back({1'b0, 32'h10});
    want.push_back({1'b0, 32'h30});
    want.push_back({1'b1, 32'h11});
    want.push_back({1'b1, 32'h31});
    gap_want = '{2, 2, 2};
`endif
    build_expected();
    run_for(want.size(), 60);
    n_cmp++; if (obs_q.size() !== want.size()) begin n_err++; $display("FAIL pkt_beat_count: got %0d want %0d", obs_q.size(), want.size()); end
    for (int k = 0; k < want.size() && k < obs_q.size(); k++) begin
      n_cmp++; if (obs_q[k] !== want[k]) begin n_err++; $display("FAIL pkt_beat[%0d]: got %h want %h", k, obs_q[k], want[k]); end
    end
    for (int k = 0; k < gap_want.size() && k + 1 < obs_cyc.size(); k++) begin
      n_cmp++;
      if (obs_cyc[k+1] - obs_cyc[k] !== gap_want[k]) begin
        n_err++; $display("FAIL pkt_spacing[%0d]: got %0d want %0d", k, obs_cyc[k+1] - obs_cyc[k], gap_want[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    bit            have_held;
    reset_dut();
    clear_queues();
    rdy_pct = 100;
    gap_pct = 0;
    for (int j = 0; j < 4; j++) push_beat(0, 32'hB0 + 32'(j), (j == 3));
    build_expected();
    run_for(2, 30);
    rdy_pct = 0;
    hs_cnt = 0;
    have_held = 1'b0;
    held = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.m_tvalid) begin
        if (!have_held) begin
          held = bus.m_tdata;
          have_held = 1'b1;
        end else begin
          n_cmp++; if (bus.m_tdata !== held) begin n_err++; $display("FAIL bp_hold[%0d]: got %h want %h", k, bus.m_tdata, held); end
        end
      end
    end
    n_cmp++; if (bus.m_tvalid !== 1'b1) begin n_err++; $display("FAIL bp_valid_held: got %b want 1", bus.m_tvalid); end
    n_cmp++; if (hs_cnt > 1) begin n_err++; $display("FAIL bp_accepts: got %0d want <=1", hs_cnt); end
    rdy_pct = 100;
    run_for(exp_q.size(), 40);
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL bp_beat_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_cmp++; if (obs_q[k] !== exp_q[k]) begin n_err++; $display("FAIL bp_beat[%0d]: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    reset_dut();
    clear_queues();
    rdy_pct = 100;
    gap_pct = 0;
    for (int j = 0; j < 4; j++) push_beat(2, 32'hD0 + 32'(j), (j == 3));
    run_for(2, 30);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_mid_m_tvalid: got %b want 0", bus.m_tvalid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.s_tready !== 4'b0000) begin n_err++; $display("FAIL rst_mid_s_tready: got %b want 0000", bus.s_tready); end
    n_cmp++; if (bus.grant_idx !== 2'd0) begin n_err++; $display("FAIL rst_mid_grant_idx: got %0d want 0", bus.grant_idx); end
    drive_idle();
    clear_queues();
    push_beat(1, 32'h0100_001E, 1'b1);
    push_beat(3, 32'h0300_003E, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    busy_prev = 1'b0;
    model_last = N - 1;
    build_expected();
    run_for(exp_q.size(), 40);
    n_cmp++; if (grant_q.size() < 1 || grant_q[0] !== 1) begin n_err++; $display("FAIL rst_mid_first_grant: got %0d want 1", (grant_q.size() > 0) ? grant_q[0] : -1); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rst_mid_beat_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_cmp++; if (obs_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rst_mid_beat[%0d]: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_random();
    int npk;
    int len;
    for (int r = 0; r < 8; r++) begin
      repeat (3) step();
      clear_queues();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(99) < 60 || (i == N - 1 && tail[0] + tail[1] + tail[2] == 0)) begin
          npk = $urandom_range(1, 3);
          for (int p = 0; p < npk; p++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) push_beat(i, {8'(i), 24'($urandom)}, (b == len - 1));
          end
        end
      end
      rdy_pct = $urandom_range(40, 100);
      gap_pct = LOCK ? 30 : 0;
      build_expected();
      run_for(exp_q.size(), 1500);
      n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rnd%0d_beat_count: got %0d want %0d", r, obs_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
        n_cmp++; if (obs_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rnd%0d_beat[%0d]: got %h want %h", r, k, obs_q[k], exp_q[k]); end
      end
    end
    gap_pct = 0;
    rdy_pct = 100;
  endtask

  initial begin
    clear_queues();
    test_reset();
    test_fairness();
    test_packet_mode();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
